// File: rtl/boot_loader_sequencer_if.sv
// Host byte link and instruction-memory write port of the boot loader sequencer.
interface boot_loader_sequencer_if #(
  parameter int INSTRUCTION_WIDTH = 32,
  parameter int PC_WIDTH          = 8
);
  logic                         byteValid;
  logic [7:0]                   byteData;
  logic                         byteReady;
  logic                         memWriteEnable;
  logic [PC_WIDTH-1:0]          memWriteAddress;
  logic [INSTRUCTION_WIDTH-1:0] memWriteData;

  modport master (
    output byteValid, byteData,
    input  byteReady, memWriteEnable, memWriteAddress, memWriteData
  );

  modport slave (
    input  byteValid, byteData,
    output byteReady, memWriteEnable, memWriteAddress, memWriteData
  );
endinterface

// File: rtl/boot_loader_sequencer.sv
// Holds the CPU in reset while a host streams a program into instruction memory.
// Define BOOT_CHECKSUM_EN to verify a trailing XOR checksum byte before release.
module boot_loader_sequencer #(
  parameter int INSTRUCTION_WIDTH = 32,
  parameter int PC_WIDTH          = 8,
  parameter int HOLD_CYCLES       = 4
) (
  input  logic                   clock,
  input  logic                   isReset,
  input  logic                   startLoad,
  boot_loader_sequencer_if.slave bus,
  output logic                   cpuReset,
  output logic                   loadDone,
  output logic                   loadError
);

  localparam int BYTES = INSTRUCTION_WIDTH / 8;
  localparam int CW    = $clog2(BYTES + 1);

  typedef enum logic [2:0] {
    WAIT_LEN,
    LOAD_BYTES,
    WRITE,
    SETTLE,
    RUN
`ifdef BOOT_CHECKSUM_EN
    ,
    CHECK,
    ERROR
`endif
  } state_t;

  state_t              state;
  logic [PC_WIDTH-1:0] lastAddress;
  logic [CW-1:0]       byteCount;
  logic [7:0]          holdCount;
  logic                accept;
`ifdef BOOT_CHECKSUM_EN
  logic [7:0]          checksum;
`endif

  always_comb begin
    bus.byteReady = 1'b0;
    case (state)
      WAIT_LEN, LOAD_BYTES: bus.byteReady = 1'b1;
`ifdef BOOT_CHECKSUM_EN
      CHECK:                bus.byteReady = 1'b1;
`endif
      default:              bus.byteReady = 1'b0;
    endcase
  end

  assign accept = bus.byteValid && bus.byteReady;

  always_ff @(posedge clock) begin
    if (isReset) begin
      state               <= WAIT_LEN;
      cpuReset            <= 1'b1;
      loadDone            <= 1'b0;
      bus.memWriteEnable  <= 1'b0;
      bus.memWriteAddress <= '0;
      bus.memWriteData    <= '0;
      byteCount           <= '0;
      holdCount           <= '0;
      lastAddress         <= '0;
`ifdef BOOT_CHECKSUM_EN
      loadError           <= 1'b0;
      checksum            <= '0;
`endif
    end else begin
      case (state)
        WAIT_LEN: begin
          if (accept) begin
            lastAddress         <= PC_WIDTH'(bus.byteData);
            bus.memWriteAddress <= '0;
            byteCount           <= '0;
`ifdef BOOT_CHECKSUM_EN
            checksum            <= '0;
`endif
            state               <= LOAD_BYTES;
          end
        end

        LOAD_BYTES: begin
          if (accept) begin
            // Bytes arrive MSB first; the cast drops the oldest byte off the top.
            bus.memWriteData <= INSTRUCTION_WIDTH'({bus.memWriteData, bus.byteData});
`ifdef BOOT_CHECKSUM_EN
            checksum         <= checksum ^ bus.byteData;
`endif
            if (byteCount == CW'(BYTES - 1)) begin
              byteCount          <= '0;
              bus.memWriteEnable <= 1'b1;
              state              <= WRITE;
            end else begin
              byteCount <= byteCount + CW'(1);
            end
          end
        end

        WRITE: begin
          bus.memWriteEnable <= 1'b0;
          if (bus.memWriteAddress == lastAddress) begin
            holdCount <= '0;
`ifdef BOOT_CHECKSUM_EN
            state     <= CHECK;
`else
            state     <= SETTLE;
`endif
          end else begin
            bus.memWriteAddress <= bus.memWriteAddress + PC_WIDTH'(1);
            state               <= LOAD_BYTES;
          end
        end

        SETTLE: begin
          if (holdCount == 8'(HOLD_CYCLES - 1)) begin
            state    <= RUN;
            cpuReset <= 1'b0;
            loadDone <= 1'b1;
          end else begin
            holdCount <= holdCount + 8'd1;
          end
        end

        RUN: begin
          if (startLoad) begin
            state    <= WAIT_LEN;
            cpuReset <= 1'b1;
            loadDone <= 1'b0;
          end
        end

`ifdef BOOT_CHECKSUM_EN
        CHECK: begin
          if (accept) begin
            holdCount <= '0;
            if (bus.byteData == checksum) begin
              state <= SETTLE;
            end else begin
              state     <= ERROR;
              loadError <= 1'b1;
            end
          end
        end

        ERROR: begin
          if (startLoad) begin
            loadError <= 1'b0;
            state     <= WAIT_LEN;
          end
        end
`endif

        default: state <= WAIT_LEN;
      endcase
    end
  end

`ifndef BOOT_CHECKSUM_EN
  assign loadError = 1'b0;
`endif

endmodule

// File: tb/tb_boot_loader_sequencer.sv
// Directed bench for boot_loader_sequencer; the checksum scenario runs only
// when BOOT_CHECKSUM_EN is defined for both bench and design.
module tb_boot_loader_sequencer;

  localparam int HOLD = 4;

  logic clock = 1'b0;
  logic isReset = 1'b1;
  logic startLoad = 1'b0;
  logic cpuReset, loadDone, loadError;

  boot_loader_sequencer_if #(.INSTRUCTION_WIDTH(32), .PC_WIDTH(8)) bus ();

  boot_loader_sequencer #(
    .INSTRUCTION_WIDTH(32),
    .PC_WIDTH(8),
    .HOLD_CYCLES(HOLD)
  ) dut (
    .clock(clock),
    .isReset(isReset),
    .startLoad(startLoad),
    .bus(bus),
    .cpuReset(cpuReset),
    .loadDone(loadDone),
    .loadError(loadError)
  );

  always #5 clock = ~clock;

  int unsigned checks = 0;
  int unsigned passed = 0;
  logic [7:0]  sum;
  int          cyc = 0;
  int          fallCyc = 0;
  int          readyInWrite = 0;
  logic        prevCpuReset = 1'b1;
  logic [7:0]  wAddr[$];
  logic [31:0] wData[$];
  int          wCyc[$];

  // Write log and cpuReset edge capture, sampled mid-cycle
  always @(negedge clock) begin
    cyc++;
    if (bus.memWriteEnable) begin
      wAddr.push_back(bus.memWriteAddress);
      wData.push_back(bus.memWriteData);
      wCyc.push_back(cyc);
      if (bus.byteReady) readyInWrite++;
    end
    if (prevCpuReset && !cpuReset) fallCyc = cyc;
    prevCpuReset = cpuReset;
  end

  task automatic cycle();
    @(posedge clock);
    #1;
  endtask

  task automatic clearLog();
    wAddr.delete();
    wData.delete();
    wCyc.delete();
    readyInWrite = 0;
  endtask

  task automatic sendByte(input logic [7:0] b);
    int unsigned n = 0;
    bus.byteValid = 1'b1;
    bus.byteData  = b;
    while (!bus.byteReady && n < 3000) begin
      cycle();
      n++;
    end
    if (!bus.byteReady) begin
      checks++;
      $display("FAIL sendByte timeout: byteReady=%b required 1", bus.byteReady);
    end
    cycle();
    bus.byteValid = 1'b0;
  endtask

  task automatic sendWord(input logic [31:0] w, input bit gap);
    for (int i = 3; i >= 0; i--) begin
      logic [7:0] b;
      b = w[i*8 +: 8];
      sum ^= b;
      sendByte(b);
      if (gap) cycle();
    end
  endtask

  task automatic finishLoad();
`ifdef BOOT_CHECKSUM_EN
    sendByte(sum);
`endif
  endtask

  task automatic pulseStartLoad();
    startLoad = 1'b1;
    cycle();
    startLoad = 1'b0;
  endtask

  task automatic waitRun(input string name);
    int unsigned n = 0;
    int unsigned bad = 0;
    while (!loadDone && n < 2000) begin
      if (bus.byteReady || !cpuReset) bad++;
      cycle();
      n++;
    end
    checks++;
    if (loadDone !== 1'b1) $display("FAIL %s reach RUN: loadDone=%b required 1", name, loadDone);
    else passed++;
    checks++;
    if (bad !== 0) $display("FAIL %s settle outputs: bad cycles=%0d required 0", name, bad);
    else passed++;
  endtask

  function automatic logic [31:0] mkWord(input int unsigned j);
    logic [7:0] b;
    b = 8'(j);
    return {b, 8'hA5, ~b, b ^ 8'h3C};
  endfunction

  task automatic test_reset();
    bus.byteValid = 1'b0;
    bus.byteData  = 8'h00;
    isReset = 1'b1;
    repeat (3) cycle();
    checks++; if (cpuReset !== 1'b1) $display("FAIL reset cpuReset: got %b required 1", cpuReset); else passed++;
    checks++; if (loadDone !== 1'b0) $display("FAIL reset loadDone: got %b required 0", loadDone); else passed++;
    checks++; if (loadError !== 1'b0) $display("FAIL reset loadError: got %b required 0", loadError); else passed++;
    checks++; if (bus.memWriteEnable !== 1'b0) $display("FAIL reset memWriteEnable: got %b required 0", bus.memWriteEnable); else passed++;
    checks++; if (bus.memWriteAddress !== 8'h00) $display("FAIL reset memWriteAddress: got %h required 00", bus.memWriteAddress); else passed++;
    checks++; if (bus.memWriteData !== 32'h0) $display("FAIL reset memWriteData: got %h required 00000000", bus.memWriteData); else passed++;
    checks++; if (bus.byteReady !== 1'b1) $display("FAIL reset byteReady: got %b required 1", bus.byteReady); else passed++;
    isReset = 1'b0;
    cycle();
  endtask

  task automatic test_single();
    int expDelay;
    clearLog();
    sum = 8'h00;
    sendByte(8'h00);
    sendWord(32'h12345678, 1'b0);
    finishLoad();
    waitRun("single");
    repeat (2) cycle();
    expDelay = HOLD + 1;
`ifdef BOOT_CHECKSUM_EN
    expDelay = HOLD + 2;
`endif
    checks++; if (wAddr.size() !== 1) $display("FAIL single write count: got %0d required 1", wAddr.size()); else passed++;
    checks++; if (wAddr[0] !== 8'h00) $display("FAIL single addr: got %h required 00", wAddr[0]); else passed++;
    checks++; if (wData[0] !== 32'h12345678) $display("FAIL single data: got %h required 12345678", wData[0]); else passed++;
    checks++; if (fallCyc - wCyc[0] !== expDelay) $display("FAIL single release delay: got %0d required %0d", fallCyc - wCyc[0], expDelay); else passed++;
    checks++; if (cpuReset !== 1'b0) $display("FAIL single cpuReset: got %b required 0", cpuReset); else passed++;
    checks++; if (loadError !== 1'b0) $display("FAIL single loadError: got %b required 0", loadError); else passed++;
  endtask

  task automatic test_toggle();
    logic [31:0] exp[3];
    exp[0] = 32'h01020304;
    exp[1] = 32'h05060708;
    exp[2] = 32'h090A0B0C;
    pulseStartLoad();
    checks++; if (cpuReset !== 1'b1 || loadDone !== 1'b0) $display("FAIL toggle restart: cpuReset=%b loadDone=%b required 1/0", cpuReset, loadDone); else passed++;
    clearLog();
    sum = 8'h00;
    sendByte(8'h02);
    cycle();
    for (int i = 0; i < 3; i++) sendWord(exp[i], 1'b1);
    finishLoad();
    waitRun("toggle");
    cycle();
    checks++; if (wAddr.size() !== 3) $display("FAIL toggle write count: got %0d required 3", wAddr.size()); else passed++;
    for (int i = 0; i < 3; i++) begin
      checks++; if (wAddr[i] !== 8'(i)) $display("FAIL toggle addr[%0d]: got %h required %h", i, wAddr[i], 8'(i)); else passed++;
      checks++; if (wData[i] !== exp[i]) $display("FAIL toggle data[%0d]: got %h required %h", i, wData[i], exp[i]); else passed++;
    end
    checks++; if (readyInWrite !== 0) $display("FAIL toggle byteReady in WRITE: got %0d cycles required 0", readyInWrite); else passed++;
  endtask

  task automatic test_back_to_back();
    clearLog();
    sum = 8'h00;
    bus.byteValid = 1'b1;
    bus.byteData  = 8'h00;
    startLoad = 1'b1;
    cycle();
    startLoad = 1'b0;
    checks++; if (cpuReset !== 1'b1) $display("FAIL priority cpuReset: got %b required 1", cpuReset); else passed++;
    checks++; if (loadDone !== 1'b0) $display("FAIL priority loadDone: got %b required 0", loadDone); else passed++;
    checks++; if (bus.byteReady !== 1'b1) $display("FAIL priority byteReady: got %b required 1", bus.byteReady); else passed++;
    sendByte(8'h00);
    sendWord(32'hDEADBEEF, 1'b0);
    finishLoad();
    waitRun("priority");
    cycle();
    checks++; if (wAddr.size() !== 1) $display("FAIL priority write count: got %0d required 1", wAddr.size()); else passed++;
    checks++; if (wData[0] !== 32'hDEADBEEF) $display("FAIL priority data: got %h required deadbeef", wData[0]); else passed++;
  endtask

  task automatic test_reset_midload();
    pulseStartLoad();
    clearLog();
    sendByte(8'h00);
    sendByte(8'h11);
    sendByte(8'h22);
    isReset = 1'b1;
    cycle();
    checks++; if (bus.byteReady !== 1'b1) $display("FAIL abort byteReady: got %b required 1", bus.byteReady); else passed++;
    checks++; if (cpuReset !== 1'b1) $display("FAIL abort cpuReset: got %b required 1", cpuReset); else passed++;
    checks++; if (bus.memWriteData !== 32'h0) $display("FAIL abort memWriteData: got %h required 00000000", bus.memWriteData); else passed++;
    isReset = 1'b0;
    repeat (2) cycle();
    checks++; if (wAddr.size() !== 0) $display("FAIL abort writes: got %0d required 0", wAddr.size()); else passed++;
    sum = 8'h00;
    sendByte(8'h00);
    sendWord(32'hCAFEBABE, 1'b0);
    finishLoad();
    waitRun("abort reload");
    cycle();
    checks++; if (wAddr.size() !== 1) $display("FAIL abort reload count: got %0d required 1", wAddr.size()); else passed++;
    checks++; if (wData[0] !== 32'hCAFEBABE) $display("FAIL abort reload data: got %h required cafebabe", wData[0]); else passed++;
  endtask

  task automatic test_full();
    int unsigned bad = 0;
    pulseStartLoad();
    clearLog();
    sum = 8'h00;
    sendByte(8'hFF);
    for (int unsigned j = 0; j < 256; j++) sendWord(mkWord(j), 1'b0);
    finishLoad();
    waitRun("full");
    repeat (3) cycle();
    checks++; if (wAddr.size() !== 256) $display("FAIL full write count: got %0d required 256", wAddr.size()); else passed++;
    for (int unsigned j = 0; j < 256 && j < wAddr.size(); j++)
      if (wAddr[j] !== 8'(j) || wData[j] !== mkWord(j)) bad++;
    checks++; if (bad !== 0) $display("FAIL full contents: got %0d bad entries required 0", bad); else passed++;
    checks++; if (wAddr[255] !== 8'hFF) $display("FAIL full last addr: got %h required ff", wAddr[255]); else passed++;
  endtask

`ifdef BOOT_CHECKSUM_EN
  task automatic test_checksum();
    int unsigned bad = 0;
    pulseStartLoad();
    clearLog();
    sendByte(8'h00);
    sendByte(8'hAA); sendByte(8'h55); sendByte(8'h0F); sendByte(8'hF0);
    sendByte(8'h00);
    waitRun("checksum good");
    checks++; if (loadError !== 1'b0) $display("FAIL checksum good loadError: got %b required 0", loadError); else passed++;
    checks++; if (wData[0] !== 32'hAA550FF0) $display("FAIL checksum good data: got %h required aa550ff0", wData[0]); else passed++;
    pulseStartLoad();
    sendByte(8'h00);
    sendByte(8'hAA); sendByte(8'h55); sendByte(8'h0F); sendByte(8'hF0);
    sendByte(8'h01);
    checks++; if (loadError !== 1'b1) $display("FAIL checksum bad loadError: got %b required 1", loadError); else passed++;
    repeat (100) begin
      if (cpuReset !== 1'b1 || loadError !== 1'b1 || loadDone !== 1'b0) bad++;
      cycle();
    end
    checks++; if (bad !== 0) $display("FAIL checksum error hold: got %0d bad cycles required 0", bad); else passed++;
    pulseStartLoad();
    checks++; if (loadError !== 1'b0) $display("FAIL checksum clear loadError: got %b required 0", loadError); else passed++;
    checks++; if (bus.byteReady !== 1'b1) $display("FAIL checksum clear byteReady: got %b required 1", bus.byteReady); else passed++;
  endtask
`endif

  initial begin
    bus.byteValid = 1'b0;
    bus.byteData  = 8'h00;
    test_reset();
    test_single();
    test_toggle();
    test_back_to_back();
    test_reset_midload();
    test_full();
`ifdef BOOT_CHECKSUM_EN
    test_checksum();
`endif
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
